// File: rtl/spi_slave_core.sv
// SPI slave with oversampled pins, any mode/word width, TX holding register and RX FIFO.
// Optional sticky overrun/underrun flags are built when SPI_SLAVE_ERR_FLAGS_EN is defined.
module spi_slave_core #(
  parameter int unsigned WORD_W     = 8,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SCK,
  input  logic              SSEL,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              frame_end,
  input  logic              err_clr,
  output logic              overrun,
  output logic              underrun
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SHIFT} state_e;

  state_e              state_q, state_d;
  logic [2:0]          sck_q, sck_d, ssel_q, ssel_d;
  logic [1:0]          mosi_q, mosi_d;
  logic                busy_q, busy_d, frame_end_q, frame_end_d;
  logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [WORD_W-2:0]   rx_shift_q, rx_shift_d;
  logic [WORD_W-1:0]   tx_shift_q, tx_shift_d, hold_q, hold_d;
  logic                reload_pend_q, reload_pend_d, hold_full_q, hold_full_d;
  logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ssel_fall, ssel_rise, mosi_s;
  logic load, push, pop, push_ok, overrun_evt, underrun_evt;
  logic [WORD_W-1:0] rx_word;

  assign sck_rise    = sck_q[1] & ~sck_q[2];
  assign sck_fall    = ~sck_q[1] & sck_q[2];
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign ssel_fall   = ~ssel_q[1] & ssel_q[2];
  assign ssel_rise   = ssel_q[1] & ~ssel_q[2];
  assign mosi_s      = mosi_q[1];
  assign rx_word     = {rx_shift_q, mosi_s};

  always_comb begin
    sck_d         = {sck_q[1:0], SCK};
    ssel_d        = {ssel_q[1:0], SSEL};
    mosi_d        = {mosi_q[0], MOSI};
    state_d       = state_q;
    busy_d        = busy_q;
    frame_end_d   = 1'b0;
    bitcnt_d      = bitcnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    reload_pend_d = reload_pend_q;
    load          = 1'b0;
    push          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ssel_fall) begin
          state_d = ST_ARM;
          busy_d  = 1'b1;
        end
      end
      ST_ARM, ST_SHIFT: begin
        if (ssel_rise) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          frame_end_d = 1'b1;
        end else if (state_q == ST_ARM) begin
          state_d  = ST_SHIFT;
          bitcnt_d = '0;
          // CPHA=0 loads now; CPHA=1 defers to the first leading edge
          reload_pend_d = CPHA;
          load          = ~CPHA;
        end else begin
          if (sample_edge) begin
            rx_shift_d = rx_word[WORD_W-2:0];
            if (bitcnt_q == BIT_W'(WORD_W - 1)) begin
              push          = 1'b1;
              bitcnt_d      = '0;
              reload_pend_d = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + BIT_W'(1);
            end
          end
          if (shift_edge) begin
            if (reload_pend_q) begin
              load          = 1'b1;
              reload_pend_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    underrun_evt = 1'b0;
    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d   = '0;
        underrun_evt = 1'b1;
      end
    end
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pop         = rx_ready && (count_q != '0);
    push_ok     = push && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
    overrun_evt = push && !push_ok;
    if (push_ok) begin
      mem_d[wr_ptr_q] = rx_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q         <= {3{CPOL}};
      ssel_q        <= '1;
      mosi_q        <= '0;
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      frame_end_q   <= 1'b0;
      bitcnt_q      <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      reload_pend_q <= 1'b0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      sck_q         <= sck_d;
      ssel_q        <= ssel_d;
      mosi_q        <= mosi_d;
      state_q       <= state_d;
      busy_q        <= busy_d;
      frame_end_q   <= frame_end_d;
      bitcnt_q      <= bitcnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      reload_pend_q <= reload_pend_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic overrun_q, overrun_d, underrun_q, underrun_d;

  always_comb begin
    overrun_d  = overrun_evt  | (overrun_q  & ~err_clr);
    underrun_d = underrun_evt | (underrun_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign overrun  = overrun_q;
  assign underrun = underrun_q;
`else
  logic unused_err;
  assign unused_err = ^{err_clr, overrun_evt, underrun_evt};
  assign overrun    = 1'b0;
  assign underrun   = 1'b0;
`endif

  assign MISO      = tx_shift_q[WORD_W-1];
  assign tx_ready  = ~hold_full_q;
  assign rx_data   = mem_q[rd_ptr_q];
  assign rx_valid  = (count_q != '0);
  assign busy      = busy_q;
  assign frame_end = frame_end_q;
endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: three instances (mode 0/8b, mode 3/16b, mode 1/8b) driven by a
// bit-level SPI master, checked against a word-level model of holding register, FIFO and flags.
module tb_spi_slave_core;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] sck = 3'b010, ssel = 3'b111, tx_valid = '0, rx_ready = '0, err_clr = '0;
  logic mosi = 1'b0;
  logic [7:0] txd0 = '0, txd2 = '0;
  logic [15:0] txd1 = '0;
  wire [2:0] miso, tx_ready, rx_valid, busy, frame_end, overrun, underrun;
  wire [7:0] rx0, rx2;
  wire [15:0] rx1;

  int checks = 0, failures = 0;
  logic [15:0] mfifo [3][4];
  int mcnt [3];
  logic [15:0] mhold [3];
  bit mhold_full [3], mover [3], munder [3], chk_en [3];
  int fe_cnt [3];

  always #5 clk = ~clk;

  spi_slave_core #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b0), .FIFO_DEPTH(4)) u_m0 (
    .clk(clk), .rst_n(rst_n), .SCK(sck[0]), .SSEL(ssel[0]), .MOSI(mosi), .MISO(miso[0]),
    .tx_data(txd0), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .rx_data(rx0),
    .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .busy(busy[0]), .frame_end(frame_end[0]),
    .err_clr(err_clr[0]), .overrun(overrun[0]), .underrun(underrun[0]));
  spi_slave_core #(.WORD_W(16), .CPOL(1'b1), .CPHA(1'b1), .FIFO_DEPTH(4)) u_m3 (
    .clk(clk), .rst_n(rst_n), .SCK(sck[1]), .SSEL(ssel[1]), .MOSI(mosi), .MISO(miso[1]),
    .tx_data(txd1), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .rx_data(rx1),
    .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .busy(busy[1]), .frame_end(frame_end[1]),
    .err_clr(err_clr[1]), .overrun(overrun[1]), .underrun(underrun[1]));
  spi_slave_core #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b1), .FIFO_DEPTH(4)) u_m1 (
    .clk(clk), .rst_n(rst_n), .SCK(sck[2]), .SSEL(ssel[2]), .MOSI(mosi), .MISO(miso[2]),
    .tx_data(txd2), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .rx_data(rx2),
    .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]), .busy(busy[2]), .frame_end(frame_end[2]),
    .err_clr(err_clr[2]), .overrun(overrun[2]), .underrun(underrun[2]));

  function automatic int wof(input int i);
    return (i == 1) ? 16 : 8;
  endfunction

  function automatic logic [15:0] rxd(input int i);
    case (i)
      0:       return {8'h00, rx0};
      1:       return rx1;
      default: return {8'h00, rx2};
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---- word-level model ----
  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0; mhold_full[i] = 0; mover[i] = 0; munder[i] = 0; mhold[i] = '0;
    end
  endtask

  task automatic m_push(input int i, input logic [15:0] w);
    if (mcnt[i] < 4) begin
      mfifo[i][mcnt[i]] = w;
      mcnt[i]++;
    end else mover[i] = 1;
  endtask

  task automatic m_pop(input int i);
    for (int k = 0; k < 3; k++) mfifo[i][k] = mfifo[i][k+1];
    mcnt[i]--;
  endtask

  task automatic m_load(input int i, output logic [15:0] w);
    if (mhold_full[i]) begin
      w = mhold[i];
      mhold_full[i] = 0;
    end else begin
      w = '0;
      munder[i] = 1;
    end
  endtask

  // ---- continuous compare against the model ----
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (chk_en[i]) begin
          check($sformatf("rx_valid[%0d]", i), rx_valid[i], mcnt[i] != 0);
          if (mcnt[i] != 0) check($sformatf("rx_data[%0d]", i), rxd(i), mfifo[i][0]);
          check($sformatf("tx_ready[%0d]", i), tx_ready[i], !mhold_full[i]);
          check($sformatf("overrun[%0d]", i), overrun[i], ERR_EN && mover[i]);
          check($sformatf("underrun[%0d]", i), underrun[i], ERR_EN && munder[i]);
          check($sformatf("busy_idle[%0d]", i), busy[i], 1'b0);
        end
      end
    end
  end

  always @(negedge clk)
    for (int i = 0; i < 3; i++) if (frame_end[i] === 1'b1) fe_cnt[i]++;

  // ---- host-side helpers ----
  task automatic wait_half();
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic hwrite(input int i, input logic [15:0] d);
    int n = 0;
    while (tx_ready[i] !== 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) check($sformatf("tx_ready_timeout[%0d]", i), tx_ready[i], 1'b1);
    case (i)
      0: txd0 = d[7:0];
      1: txd1 = d;
      default: txd2 = d[7:0];
    endcase
    tx_valid[i] = 1'b1;
    @(posedge clk); #1;
    tx_valid[i] = 1'b0;
    mhold[i] = d;
    mhold_full[i] = 1;
  endtask

  task automatic hpop(input int i, input logic [15:0] exp_w);
    check($sformatf("pop_valid[%0d]", i), rx_valid[i], 1'b1);
    check($sformatf("pop_data[%0d]", i), rxd(i), exp_w);
    rx_ready[i] = 1'b1;
    @(posedge clk); #1;
    rx_ready[i] = 1'b0;
    m_pop(i);
  endtask

  task automatic eclr(input int i);
    err_clr[i] = 1'b1;
    @(posedge clk); #1;
    err_clr[i] = 1'b0;
    mover[i] = 0;
    munder[i] = 0;
  endtask

  task automatic pulse_pop(input int i);
    repeat (2) @(posedge clk);
    #1 rx_ready[i] = 1'b1;
    @(posedge clk);
    #1 rx_ready[i] = 1'b0;
  endtask

  // SPI master: nbits MSB-first from mo; returns MISO bits captured on the sample edges
  task automatic frame(input int i, input int nbits, input logic [63:0] mo,
                       output logic [63:0] mi, input bit no_model, input bit pop_sync);
    int w = wof(i);
    bit cp = (i == 1);
    bit ch = (i != 0);
    logic [63:0] expmi = '0;
    logic [15:0] cur = '0;
    int fe0 = fe_cnt[i];
    chk_en[i] = 0;
    mi = '0;
    ssel[i] = 1'b0;
    wait_half();
    for (int j = 0; j < nbits; j++) begin
      if (!ch) begin
        if (j == 0) m_load(i, cur);
        mosi = mo[nbits-1-j];
        wait_half();
        sck[i] = ~cp;
      end else begin
        if (j % w == 0) m_load(i, cur);
        sck[i] = ~cp;
        mosi = mo[nbits-1-j];
        wait_half();
        sck[i] = cp;
      end
      mi = {mi[62:0], miso[i]};
      expmi = {expmi[62:0], cur[w-1]};
      cur = cur << 1;
      if (j == 0 && !no_model) check($sformatf("busy_frame[%0d]", i), busy[i], 1'b1);
      if (pop_sync && j == nbits - 1) fork pulse_pop(i); join_none
      wait_half();
      if (!ch) begin
        sck[i] = cp;
        if ((j + 1) % w == 0) m_load(i, cur);
      end
    end
    wait_half();
    ssel[i] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    if (!no_model) begin
      check($sformatf("miso_bits[%0d]", i), mi, expmi);
      check($sformatf("frame_end_pulses[%0d]", i), fe_cnt[i] - fe0, 1);
      if (pop_sync) m_pop(i);
      for (int k = 0; k < nbits / w; k++)
        m_push(i, 16'((mo >> (nbits - (k + 1) * w)) & ((64'h1 << w) - 1)));
      chk_en[i] = 1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] mi;
    m_reset();
    for (int i = 0; i < 3; i++) begin chk_en[i] = 0; fe_cnt[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_miso[%0d]", i), miso[i], 1'b0);
      check($sformatf("rst_tx_ready[%0d]", i), tx_ready[i], 1'b1);
      check($sformatf("rst_rx_valid[%0d]", i), rx_valid[i], 1'b0);
      check($sformatf("rst_rx_data[%0d]", i), rxd(i), 16'h0000);
      check($sformatf("rst_busy[%0d]", i), busy[i], 1'b0);
      check($sformatf("rst_frame_end[%0d]", i), frame_end[i], 1'b0);
      check($sformatf("rst_flags[%0d]", i), {overrun[i], underrun[i]}, 2'b00);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_en[i] = 1;

    // mode 0, 8 bit: 0xA5 out, 0x3C in
    hwrite(0, 16'h00A5);
    frame(0, 8, 64'h3C, mi, 0, 0);
    check("m0_miso_lit", mi, 64'hA5);
    hpop(0, 16'h003C);
    eclr(0);

    // mode 3, 16 bit: preload, refill once tx_ready rises mid-word
    hwrite(1, 16'h1234);
    fork
      frame(1, 32, 64'h0001_0002, mi, 0, 0);
      hwrite(1, 16'hBEEF);
    join
    check("m3_miso_lit", mi, 64'h1234_BEEF);
    hpop(1, 16'h0001);
    hpop(1, 16'h0002);

    // mode 1, empty holding register: zeros out, underrun sticky until cleared
    frame(2, 8, 64'h5A, mi, 0, 0);
    check("m1_miso_lit", mi, 64'h0);
    repeat (4) @(posedge clk);
    #1;
    check("m1_underrun_lit", underrun[2], ERR_EN);
    eclr(2);
    check("m1_underrun_clr", underrun[2], 1'b0);
    hpop(2, 16'h005A);

    // five words into a 4-deep FIFO with no pops: fifth dropped
    frame(0, 40, 64'h11_22_33_44_55, mi, 0, 0);
    check("ovr_lit", overrun[0], ERR_EN);
    hpop(0, 16'h0011);
    hpop(0, 16'h0022);
    hpop(0, 16'h0033);
    hpop(0, 16'h0044);
    check("ovr_empty_lit", rx_valid[0], 1'b0);
    eclr(0);

    // full FIFO: pop coincident with push is accepted
    frame(0, 32, 64'hA1A2A3A4, mi, 0, 0);
    frame(0, 8, 64'hB5, mi, 0, 1);
    check("popsync_no_ovr", overrun[0], 1'b0);
    hpop(0, 16'h00A2);
    hpop(0, 16'h00A3);
    hpop(0, 16'h00A4);
    hpop(0, 16'h00B5);
    eclr(0);

    // aborted 5-bit frame, then a normal one
    frame(0, 5, 64'h16, mi, 0, 0);
    check("partial_no_push", rx_valid[0], 1'b0);
    frame(0, 8, 64'h81, mi, 0, 0);
    hpop(0, 16'h0081);
    eclr(0);

    // reset mid-word with two words queued
    frame(0, 16, 64'hC3D4, mi, 0, 0);
    hwrite(0, 16'h00FF);
    for (int i = 0; i < 3; i++) chk_en[i] = 0;
    fork
      frame(0, 8, 64'h00, mi, 1, 0);
      begin
        repeat (40) @(posedge clk);
        #1;
        check("pre_rst_miso", miso[0], 1'b1);
        check("pre_rst_rx_valid", rx_valid[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rx_valid", rx_valid[0], 1'b0);
        check("mid_rst_tx_ready", tx_ready[0], 1'b1);
        check("mid_rst_miso", miso[0], 1'b0);
        m_reset();
      end
    join
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_en[i] = 1;
    hwrite(0, 16'h0096);
    frame(0, 8, 64'h69, mi, 0, 0);
    check("post_rst_miso_lit", mi, 64'h96);
    hpop(0, 16'h0069);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
